// File: rtl/tagged_instr_sequencer.sv
// Tagged-union instruction sequencer: fetches {tag,payload} words, owns the PC,
// and hands Alu payloads to the shared ALU over a valid/ready + done handshake.
module tagged_instr_sequencer #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned PLD_W = 14,
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [PC_W-1:0]     start_pc,
  output logic                fetch_req,
  output logic [PC_W-1:0]     fetch_addr,
  input  logic                fetch_ack,
  input  logic [PLD_W+1:0]    fetch_data,
  output logic                alu_valid,
  output logic [PLD_W-1:0]    alu_payload,
  input  logic                alu_ready,
  input  logic                alu_done,
  output logic                busy,
  output logic                halted,
  output logic [PC_W-1:0]     pc,
  output logic [CNT_W-1:0]    retired
);

  localparam int unsigned INSTR_W = 2 + PLD_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_ISSUE  = 3'd3,
    S_WAIT   = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    TAG_NOP  = 2'd0,
    TAG_JMP  = 2'd1,
    TAG_ALU  = 2'd2,
    TAG_HALT = 2'd3
  } tag_e;

  state_e               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [CNT_W-1:0]     ret_q, ret_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;

  tag_e                 tag;
  logic [PC_W-1:0]      pc_inc;
  logic [CNT_W-1:0]     ret_inc;

  assign tag     = tag_e'(instr_q[INSTR_W-1 -: 2]);
  assign pc_inc  = pc_q + PC_W'(1);
  // Retired count sticks at all-ones instead of wrapping.
  assign ret_inc = (ret_q == '1) ? ret_q : ret_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ret_q   <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ret_q   <= ret_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ret_d   = ret_q;
    instr_d = instr_q;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d    = start_pc;
          ret_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (fetch_ack) begin
          instr_d = fetch_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (tag)
          TAG_NOP: begin
            pc_d    = pc_inc;
            ret_d   = ret_inc;
            state_d = S_FETCH;
          end
          TAG_JMP: begin
            pc_d    = instr_q[PC_W-1:0];
            ret_d   = ret_inc;
            state_d = S_FETCH;
          end
          TAG_ALU: begin
            state_d = S_ISSUE;
          end
          TAG_HALT: begin
            ret_d   = ret_inc;
            state_d = S_HALT;
          end
        endcase
      end
      S_ISSUE: begin
        if (alu_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (alu_done) begin
          pc_d    = pc_inc;
          ret_d   = ret_inc;
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign fetch_req   = (state_q == S_FETCH);
  assign fetch_addr  = fetch_req ? pc_q : '0;
  assign alu_valid   = (state_q == S_ISSUE);
  assign alu_payload = instr_q[PLD_W-1:0];
  assign halted      = (state_q == S_HALT);
  assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
  assign pc          = pc_q;
  assign retired     = ret_q;

endmodule

// File: tb/tb_tagged_instr_sequencer.sv
// Directed bench for tagged_instr_sequencer: ROM responder with programmable ack
// delay, hand-driven ALU handshake, and a CNT_W=2 instance for saturation.
module tb_tagged_instr_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        rst, start, fetch_ack, alu_ready, alu_done;
  logic [7:0]  start_pc, fetch_addr, pc;
  logic [15:0] fetch_data, retired;
  logic [13:0] alu_payload;
  logic        fetch_req, alu_valid, busy, halted;

  // Narrow-counter instance
  logic        rst2, start2, fetch_ack2;
  logic [7:0]  start_pc2, fetch_addr2, pc2;
  logic [15:0] fetch_data2;
  logic [13:0] alu_payload2;
  logic [1:0]  retired2;
  logic        fetch_req2, alu_valid2, busy2, halted2;

  tagged_instr_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .start_pc(start_pc),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
    .fetch_data(fetch_data), .alu_valid(alu_valid), .alu_payload(alu_payload),
    .alu_ready(alu_ready), .alu_done(alu_done), .busy(busy), .halted(halted),
    .pc(pc), .retired(retired)
  );

  tagged_instr_sequencer #(.PC_W(8), .PLD_W(14), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .start_pc(start_pc2),
    .fetch_req(fetch_req2), .fetch_addr(fetch_addr2), .fetch_ack(fetch_ack2),
    .fetch_data(fetch_data2), .alu_valid(alu_valid2), .alu_payload(alu_payload2),
    .alu_ready(1'b0), .alu_done(1'b0), .busy(busy2), .halted(halted2),
    .pc(pc2), .retired(retired2)
  );

  logic [15:0] rom [256];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          ack_dly = 0;
  int          wait_cnt = 0;
  int          alu_valid_cnt = 0;
  int          both_cnt = 0;
  logic [7:0]  addr_log [$];
  int          cyc_log [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // ROM responder: acks ack_dly cycles after fetch_req is first seen
  always @(negedge clk) begin
    fetch_ack = 1'b0;
    if (fetch_req) begin
      if (wait_cnt == ack_dly) begin
        fetch_ack  = 1'b1;
        fetch_data = rom[fetch_addr];
        addr_log.push_back(fetch_addr);
        cyc_log.push_back(cyc);
        wait_cnt   = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  always @(negedge clk) begin
    fetch_ack2 = fetch_req2;
    if (fetch_req2) fetch_data2 = rom[fetch_addr2];
  end

  always @(negedge clk) begin
    if (alu_valid) alu_valid_cnt++;
    if (alu_valid && fetch_req) both_cnt++;
  end

  task automatic do_start(input logic [7:0] p);
    start_pc = p;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_halt(input string tag, input int budget);
    int k = 0;
    while (!halted && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, {31'd0, halted}, 32'd1);
  endtask

  task automatic wait_alu_valid(input string tag, input int budget);
    int k = 0;
    while (!alu_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, {31'd0, alu_valid}, 32'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_req"},   {31'd0, fetch_req}, 32'd0);
    check({tag, "_valid"}, {31'd0, alu_valid}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy},      32'd0);
    check({tag, "_halt"},  {31'd0, halted},    32'd0);
    check({tag, "_pc"},    {24'd0, pc},        32'd0);
    check({tag, "_ret"},   {16'd0, retired},   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int unsigned i = 0; i < 256; i++) rom[i] = 16'hC000;
    rst = 1'b1; start = 1'b0; start_pc = '0; alu_ready = 1'b0; alu_done = 1'b0;
    rst2 = 1'b1; start2 = 1'b0; start_pc2 = '0;
    fetch_data = '0; fetch_data2 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0; rst2 = 1'b0;
    @(negedge clk);
    check_idle("rst");
    check("rst2_busy",    {31'd0, busy2},       32'd0);
    check("rst2_valid",   {31'd0, alu_valid2},  32'd0);
    check("rst2_payload", {18'd0, alu_payload2}, 32'd0);
    check("rst_addr",     {24'd0, fetch_addr},  32'd0);

    // 1: NOP then HALT, ack after 2 cycles
    rom[8'h10] = 16'h0000; rom[8'h11] = 16'hC000;
    ack_dly = 2; addr_log.delete(); cyc_log.delete();
    do_start(8'h10);
    check("t1_busy", {31'd0, busy},      32'd1);
    check("t1_req",  {31'd0, fetch_req}, 32'd1);
    check("t1_addr", {24'd0, fetch_addr}, 32'h10);
    wait_halt("t1_halt", 50);
    check("t1_nfetch", addr_log.size(), 32'd2);
    if (addr_log.size() == 2) begin
      check("t1_addr0", {24'd0, addr_log[0]}, 32'h10);
      check("t1_addr1", {24'd0, addr_log[1]}, 32'h11);
    end
    check("t1_pc",   {24'd0, pc},      32'h11);
    check("t1_ret",  {16'd0, retired}, 32'd2);
    check("t1_busy_end", {31'd0, busy}, 32'd0);

    // 2: JMP 40 then HALT, ack in the req-entry cycle
    rom[8'h00] = 16'h4040; rom[8'h40] = 16'hC000;
    ack_dly = 0; addr_log.delete(); cyc_log.delete(); alu_valid_cnt = 0;
    do_start(8'h00);
    wait_halt("t2_halt", 50);
    check("t2_nfetch", addr_log.size(), 32'd2);
    if (addr_log.size() == 2) begin
      check("t2_addr1",   {24'd0, addr_log[1]}, 32'h40);
      check("t2_latency", cyc_log[1] - cyc_log[0], 32'd2);
    end
    check("t2_ret",   {16'd0, retired}, 32'd2);
    check("t2_pc",    {24'd0, pc},      32'h40);
    check("t2_noalu", alu_valid_cnt,    32'd0);

    // 3: ALU 1234, ready low 3 cycles, done 4 cycles after transfer
    rom[8'h05] = 16'h9234; rom[8'h06] = 16'hC000;
    addr_log.delete(); alu_valid_cnt = 0;
    do_start(8'h05);
    wait_alu_valid("t3_issue", 20);
    for (int i = 0; i < 3; i++) begin
      check("t3_hold_valid", {31'd0, alu_valid}, 32'd1);
      check("t3_hold_pld",   {18'd0, alu_payload}, 32'h1234);
      @(negedge clk);
    end
    check("t3_xfer_valid", {31'd0, alu_valid}, 32'd1);
    check("t3_xfer_pld",   {18'd0, alu_payload}, 32'h1234);
    alu_ready = 1'b1; alu_done = 1'b1;
    @(negedge clk);
    alu_ready = 1'b0; alu_done = 1'b0;
    check("t3_wait_valid", {31'd0, alu_valid}, 32'd0);
    check("t3_wait_pc",    {24'd0, pc},        32'h05);
    check("t3_wait_busy",  {31'd0, busy},      32'd1);
    repeat (3) @(negedge clk);
    check("t3_wait_pc2",   {24'd0, pc},        32'h05);
    alu_done = 1'b1;
    @(negedge clk);
    alu_done = 1'b0;
    check("t3_pc",   {24'd0, pc},         32'h06);
    check("t3_req",  {31'd0, fetch_req},  32'd1);
    check("t3_addr", {24'd0, fetch_addr}, 32'h06);
    wait_halt("t3_halt", 50);
    check("t3_valid_cycles", alu_valid_cnt, 32'd4);
    check("t3_ret", {16'd0, retired}, 32'd2);

    // 4: PC wrap FF -> 00, restarted from HALT
    rom[8'hFF] = 16'h0000; rom[8'h00] = 16'hC000;
    addr_log.delete();
    do_start(8'hFF);
    check("t4_ret_clr", {16'd0, retired}, 32'd0);
    wait_halt("t4_halt", 50);
    check("t4_pc",  {24'd0, pc},      32'h00);
    check("t4_ret", {16'd0, retired}, 32'd2);
    if (addr_log.size() == 2) check("t4_addr1", {24'd0, addr_log[1]}, 32'h00);
    else check("t4_nfetch", addr_log.size(), 32'd2);

    // 5a: reset during WAIT, later alu_done ignored
    rom[8'h05] = 16'h9234;
    do_start(8'h05);
    wait_alu_valid("t5_issue", 20);
    alu_ready = 1'b1;
    @(negedge clk);
    alu_ready = 1'b0;
    check("t5_in_wait", {31'd0, busy & ~alu_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("t5w");
    alu_done = 1'b1;
    @(negedge clk);
    alu_done = 1'b0;
    @(negedge clk);
    check_idle("t5w_done");

    // 5b: start ignored in FETCH, then reset during FETCH
    ack_dly = 10;
    do_start(8'h20);
    start_pc = 8'h77; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t5_pc_keep",   {24'd0, pc},         32'h20);
    check("t5_addr_keep", {24'd0, fetch_addr}, 32'h20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("t5f");
    check("t5_never_both", both_cnt, 32'd0);

    // 6: CNT_W=2 saturation, then restart from HALT
    for (int unsigned a = 8'h30; a < 8'h35; a++) rom[a] = 16'h0000;
    rom[8'h35] = 16'hC000;
    start_pc2 = 8'h30; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int k = 0; k < 60 && !halted2; k++) @(negedge clk);
    check("t6_halt", {31'd0, halted2},  32'd1);
    check("t6_sat",  {30'd0, retired2}, 32'd3);
    check("t6_pc",   {24'd0, pc2},      32'h35);
    start_pc2 = 8'h35; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    check("t6_ret_clr", {30'd0, retired2}, 32'd0);
    for (int k = 0; k < 20 && !halted2; k++) @(negedge clk);
    check("t6_halt2", {31'd0, halted2},  32'd1);
    check("t6_ret2",  {30'd0, retired2}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
